// File: rtl/prog_run_ctrl.sv
// Program-run controller: owns the program counter, the Start/Ack run
// handshake, halt/timeout detection and the cycle/instruction/branch
// performance counters for the processor top level.
module prog_run_ctrl #(
  parameter int PC_W     = 10,
  parameter int INST_W   = 9,
  parameter int CNT_W    = 16,
  parameter int NUM_PROG = 4,
  parameter int SEL_W    = (NUM_PROG > 1) ? $clog2(NUM_PROG) : 1,
  parameter int TIMEOUT  = 0
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  logic                     Start,
  input  logic [SEL_W-1:0]         ProgSel,
  input  logic [NUM_PROG*PC_W-1:0] ProgBase,
  input  logic [INST_W-1:0]        Instruction,
  input  logic                     BranchAbs,
  input  logic                     BranchRelEn,
  input  logic                     ALU_flag,
  input  logic [PC_W-1:0]          Target,
  input  logic                     Stall,
  output logic [PC_W-1:0]          ProgCtr,
  output logic                     Run,
  output logic                     Ack,
  output logic                     TimedOut,
  output logic [CNT_W-1:0]         CycleCt,
  output logic [CNT_W-1:0]         InstCt,
  output logic [CNT_W-1:0]         BranchCt
);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    RUN,
    DONE
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [PC_W-1:0] base_sel;
  logic            halt;
  logic            timeout_hit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Entry-point mux; out-of-range selects fall back to slot 0
  always_comb begin
    base_sel = ProgBase[0 +: PC_W];
    for (int unsigned k = 0; k < NUM_PROG; k++) begin
      if (ProgSel == SEL_W'(k)) base_sel = ProgBase[k*PC_W +: PC_W];
    end
  end

  // Halt is the all-ones opcode; timeout fires on the last permitted RUN cycle
  always_comb begin
    halt        = &Instruction;
    timeout_hit = (TIMEOUT != 0) && (32'(CycleCt) == 32'(TIMEOUT - 1));
  end

  // State register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state: Start always wins (abort from RUN), then halt, then timeout
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (Start) state_nxt = ARM;
      ARM:        if (!Start) state_nxt = RUN;
      RUN: begin
        if (Start)                    state_nxt = ARM;
        else if (halt || timeout_hit) state_nxt = DONE;
      end
      default:    state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from the state register
  always_comb begin
    Run = (state == RUN);
    Ack = (state == DONE);
  end

  // PC, counters and timeout flag; the RUN branch encodes halt > timeout > stall > advance
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ProgCtr  <= '0;
      TimedOut <= 1'b0;
      CycleCt  <= '0;
      InstCt   <= '0;
      BranchCt <= '0;
    end else begin
      case (state)
        ARM: begin
          if (Start) begin
            ProgCtr  <= base_sel;
            TimedOut <= 1'b0;
            CycleCt  <= '0;
            InstCt   <= '0;
            BranchCt <= '0;
          end
        end
        RUN: begin
          if (!Start) begin
            CycleCt <= sat_inc(CycleCt);
            if (halt) begin
              // final cycle: PC and instruction count hold
            end else if (timeout_hit) begin
              TimedOut <= 1'b1;
            end else if (!Stall) begin
              InstCt <= sat_inc(InstCt);
              if (BranchAbs) begin
                ProgCtr  <= Target;
                BranchCt <= sat_inc(BranchCt);
              end else if (BranchRelEn && ALU_flag) begin
                ProgCtr  <= ProgCtr + Target;
                BranchCt <= sat_inc(BranchCt);
              end else begin
                ProgCtr <= ProgCtr + 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_run_ctrl.sv
// Self-checking bench for prog_run_ctrl: directed scenarios plus randomized
// runs checked against a cycle-level behavioural model of the run rules.
module tb_prog_run_ctrl;

  localparam int TO   = 20;
  localparam int CMAX = 65535;
  localparam logic [8:0] HALT = 9'h1FF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  prog_sel;
  logic [39:0] prog_base;
  logic        branch_abs, branch_rel_en, alu_flag, stall;
  logic [9:0]  target;

  logic [9:0]  pc, pc_s;
  logic [8:0]  instr, instr_s;
  logic        run, ack, tout, run_s, ack_s, tout_s;
  logic [15:0] cyc, ict, bct;
  logic [3:0]  cyc_s, ict_s, bct_s;

  logic [8:0]  rom [0:1023];

  int checks = 0;
  int failures = 0;

  // model state
  int m_pc, m_cyc, m_inst, m_br;
  bit m_done, m_to;

  assign instr   = rom[pc];
  assign instr_s = rom[pc_s];

  always #5 clk = ~clk;

  prog_run_ctrl #(.TIMEOUT(TO)) dut (
    .Clk(clk), .Reset_n(rst_n), .Start(start), .ProgSel(prog_sel),
    .ProgBase(prog_base), .Instruction(instr), .BranchAbs(branch_abs),
    .BranchRelEn(branch_rel_en), .ALU_flag(alu_flag), .Target(target),
    .Stall(stall), .ProgCtr(pc), .Run(run), .Ack(ack), .TimedOut(tout),
    .CycleCt(cyc), .InstCt(ict), .BranchCt(bct)
  );

  prog_run_ctrl #(.CNT_W(4), .TIMEOUT(0)) dut_s (
    .Clk(clk), .Reset_n(rst_n), .Start(start), .ProgSel(prog_sel),
    .ProgBase(prog_base), .Instruction(instr_s), .BranchAbs(branch_abs),
    .BranchRelEn(branch_rel_en), .ALU_flag(alu_flag), .Target(target),
    .Stall(stall), .ProgCtr(pc_s), .Run(run_s), .Ack(ack_s), .TimedOut(tout_s),
    .CycleCt(cyc_s), .InstCt(ict_s), .BranchCt(bct_s)
  );

  task automatic clear_rom();
    for (int i = 0; i < 1024; i++) rom[i] = 9'h000;
  endtask

  // Hold Start for two edges (enter ARM, load base), drop it, step into RUN
  task automatic launch(input logic [1:0] sel);
    logic [9:0] base;
    base = prog_base[sel*10 +: 10];
    start = 1'b1; prog_sel = sel;
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    m_pc = base; m_cyc = 0; m_inst = 0; m_br = 0; m_done = 0; m_to = 0;
    checks++;
    if (pc !== base || run !== 1'b1 || cyc !== 16'd0 || tout !== 1'b0) begin
      failures++;
      $display("FAIL launch: pc=%0h run=%0b cyc=%0d to=%0b required pc=%0h run=1 cyc=0 to=0",
               pc, run, cyc, tout, base);
    end
  endtask

  // Apply one cycle of inputs, advance the model by the run rules, compare after the edge
  task automatic run_cycle(input logic s, input logic ab, input logic re,
                           input logic fl, input logic [9:0] tg);
    logic [8:0] ins;
    int prev;
    stall = s; branch_abs = ab; branch_rel_en = re; alu_flag = fl; target = tg;
    if (!m_done) begin
      ins  = rom[m_pc];
      prev = m_cyc;
      if (m_cyc < CMAX) m_cyc++;
      if (ins == HALT) begin
        m_done = 1;
      end else if (prev == TO - 1) begin
        m_done = 1; m_to = 1;
      end else if (!s) begin
        if (m_inst < CMAX) m_inst++;
        if (ab) begin
          m_pc = int'(tg); m_br++;
        end else if (re && fl) begin
          m_pc = (m_pc + int'(tg)) % 1024; m_br++;
        end else begin
          m_pc = (m_pc + 1) % 1024;
        end
      end
    end
    @(posedge clk); #1;
    checks++;
    if (pc !== 10'(m_pc) || ack !== m_done || run !== !m_done || tout !== m_to) begin
      failures++;
      $display("FAIL cycle: pc=%0h ack=%0b run=%0b to=%0b required pc=%0h ack=%0b run=%0b to=%0b",
               pc, ack, run, tout, m_pc, m_done, !m_done, m_to);
    end
  endtask

  task automatic check_counters(input string name);
    checks++;
    if (cyc !== 16'(m_cyc) || ict !== 16'(m_inst) || bct !== 16'(m_br)) begin
      failures++;
      $display("FAIL %s counters: cyc=%0d inst=%0d br=%0d required cyc=%0d inst=%0d br=%0d",
               name, cyc, ict, bct, m_cyc, m_inst, m_br);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++;
    if (pc !== 10'h0 || run !== 1'b0 || ack !== 1'b0 || tout !== 1'b0 ||
        cyc !== 16'd0 || ict !== 16'd0 || bct !== 16'd0) begin
      failures++;
      $display("FAIL reset: pc=%0h run=%0b ack=%0b to=%0b cyc=%0d inst=%0d br=%0d required all zero",
               pc, run, ack, tout, cyc, ict, bct);
    end
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_sequential();
    clear_rom();
    rom[10'h045] = HALT;
    launch(2'd2);
    for (int i = 0; i < 6; i++) run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 10'h0);
    checks++;
    if (pc !== 10'h045 || ack !== 1'b1 || cyc !== 16'd6 || ict !== 16'd5 || bct !== 16'd0) begin
      failures++;
      $display("FAIL sequential: pc=%0h ack=%0b cyc=%0d inst=%0d br=%0d required 45 1 6 5 0",
               pc, ack, cyc, ict, bct);
    end
    check_counters("sequential");
  endtask

  task automatic test_branches();
    clear_rom();
    rom[10'h200] = HALT;
    launch(2'd1);
    run_cycle(1'b0, 1'b0, 1'b1, 1'b1, 10'h3FE);
    checks++;
    if (pc !== 10'h00E) begin
      failures++;
      $display("FAIL rel_taken: pc=%0h required e", pc);
    end
    run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 10'h0);
    run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 10'h0);
    run_cycle(1'b0, 1'b0, 1'b1, 1'b0, 10'h3FE);
    checks++;
    if (pc !== 10'h011) begin
      failures++;
      $display("FAIL rel_not_taken: pc=%0h required 11", pc);
    end
    run_cycle(1'b0, 1'b1, 1'b1, 1'b1, 10'h200);
    checks++;
    if (pc !== 10'h200) begin
      failures++;
      $display("FAIL abs_jump: pc=%0h required 200", pc);
    end
    run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 10'h0);
    checks++;
    if (bct !== 16'd2 || ict !== 16'd5 || cyc !== 16'd6 || ack !== 1'b1) begin
      failures++;
      $display("FAIL branch_counts: br=%0d inst=%0d cyc=%0d ack=%0b required 2 5 6 1",
               bct, ict, cyc, ack);
    end
  endtask

  task automatic test_stall();
    logic [7:0] pat;
    pat = 8'b0001_0110;
    clear_rom();
    rom[10'h084] = HALT;
    launch(2'd0);
    for (int i = 0; i < 8; i++) run_cycle(pat[i], 1'b0, 1'b0, 1'b0, 10'h0);
    checks++;
    if (cyc !== 16'd8 || ict !== 16'd4 || pc !== 10'h084 || ack !== 1'b1) begin
      failures++;
      $display("FAIL stall: cyc=%0d inst=%0d pc=%0h ack=%0b required 8 4 84 1", cyc, ict, pc, ack);
    end
  endtask

  task automatic test_timeout();
    clear_rom();
    launch(2'd0);
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (ack !== 1'b0) begin
        failures++;
        $display("FAIL timeout_early: ack=%0b at cycle %0d required 0", ack, i);
      end
      run_cycle(1'b0, 1'b0, (i % 4) == 3, 1'b1, 10'h3FD);
    end
    checks++;
    if (ack !== 1'b1 || tout !== 1'b1 || cyc !== 16'd20) begin
      failures++;
      $display("FAIL timeout: ack=%0b to=%0b cyc=%0d required 1 1 20", ack, tout, cyc);
    end
    run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 10'h0);
    check_counters("timeout_frozen");
  endtask

  task automatic test_timeout_halt_sat();
    clear_rom();
    rom[10'h093] = HALT;
    launch(2'd0);
    for (int i = 0; i < 20; i++) run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 10'h0);
    checks++;
    if (ack !== 1'b1 || tout !== 1'b0 || cyc !== 16'd20 || ict !== 16'd19) begin
      failures++;
      $display("FAIL halt_at_limit: ack=%0b to=%0b cyc=%0d inst=%0d required 1 0 20 19",
               ack, tout, cyc, ict);
    end
    checks++;
    if (ack_s !== 1'b1 || cyc_s !== 4'd15 || ict_s !== 4'd15 || tout_s !== 1'b0) begin
      failures++;
      $display("FAIL saturate: ack=%0b cyc=%0d inst=%0d to=%0b required 1 15 15 0",
               ack_s, cyc_s, ict_s, tout_s);
    end
  endtask

  task automatic test_abort();
    clear_rom();
    rom[10'h302] = HALT;
    launch(2'd3);
    for (int i = 0; i < 3; i++) run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 10'h0);
    start = 1'b1; prog_sel = 2'd3;
    @(posedge clk); #1;
    checks++;
    if (run !== 1'b0 || ack !== 1'b0) begin
      failures++;
      $display("FAIL abort_arm: run=%0b ack=%0b required 0 0", run, ack);
    end
    @(posedge clk); #1;
    checks++;
    if (pc !== 10'h300 || cyc !== 16'd0 || ict !== 16'd0 || ack !== 1'b0) begin
      failures++;
      $display("FAIL abort_clear: pc=%0h cyc=%0d inst=%0d ack=%0b required 300 0 0 0",
               pc, cyc, ict, ack);
    end
    start = 1'b0;
    @(posedge clk); #1;
    m_pc = 'h300; m_cyc = 0; m_inst = 0; m_br = 0; m_done = 0; m_to = 0;
    for (int i = 0; i < 3; i++) run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 10'h0);
    check_counters("abort_rerun");
  endtask

  task automatic test_reset_mid_run();
    clear_rom();
    launch(2'd2);
    run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 10'h0);
    run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 10'h0);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (pc !== 10'h0 || run !== 1'b0 || ack !== 1'b0 || cyc !== 16'd0 || ict !== 16'd0) begin
      failures++;
      $display("FAIL reset_async: pc=%0h run=%0b ack=%0b cyc=%0d inst=%0d required all zero",
               pc, run, ack, cyc, ict);
    end
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (run !== 1'b0 || pc !== 10'h0) begin
      failures++;
      $display("FAIL reset_idle: run=%0b pc=%0h required 0 0", run, pc);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < 1024; i++)
        rom[i] = ($urandom_range(0, 15) == 0) ? HALT : 9'($urandom_range(0, 510));
      prog_base = {$urandom(), $urandom()};
      launch(2'($urandom_range(0, 3)));
      for (int c = 0; c < 40 && !m_done; c++)
        run_cycle($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 3) == 0, 1'($urandom), 10'($urandom));
      checks++;
      if (!m_done) begin
        failures++;
        $display("FAIL random_bound: run %0d did not finish, ack=%0b required 1", it, ack);
      end
      check_counters("random");
    end
  endtask

  initial begin
    start = 1'b0; prog_sel = 2'd0;
    branch_abs = 1'b0; branch_rel_en = 1'b0; alu_flag = 1'b0; stall = 1'b0; target = '0;
    prog_base = {10'h300, 10'h040, 10'h010, 10'h080};
    clear_rom();
    test_reset();
    test_sequential();
    test_branches();
    test_stall();
    test_timeout();
    test_timeout_halt_sat();
    test_abort();
    test_reset_mid_run();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
